// File: rtl/apb_up_master_pkg.sv
// Shared types and constants for the APB up-master.
package apb_up_master_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } apb_mst_state_e;

    localparam int unsigned DefaultTimeoutCycles = 255;

    // Wait-counter width: enough bits for the timeout value, kept within 8..16 bits.
    function automatic int unsigned wait_cnt_width(input int unsigned timeout_cycles);
        int unsigned w;
        w = $clog2(timeout_cycles + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/apb_up_master.sv
// APB3 initiator: one valid/ready request in, one APB transfer out, one response back.
module apb_up_master
    import apb_up_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int unsigned CntW      = wait_cnt_width(TIMEOUT_CYCLES);
    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    // Abort once the counter has seen TIMEOUT_CYCLES-1 earlier wait cycles, i.e. on the
    // TIMEOUT_CYCLES-th ACCESS cycle without PREADY.
    localparam logic [CntW-1:0] WaitLast =
        TimeoutEn ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    apb_mst_state_e            state_q;
    logic [CntW-1:0]           wait_q;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;
    logic                      tmo_q;

    // Transfer FSM with registered request fields, wait counter and response fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            wait_q   <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        paddr_q  <= req_addr_i;
                        pwdata_q <= req_wdata_i;
                        pwrite_q <= req_write_i;
                        wait_q   <= '0;
                        state_q  <= StSetup;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                end
                StAccess: begin
                    // PREADY takes priority over a coincident timeout.
                    if (PREADY) begin
                        rdata_q <= pwrite_q ? '0 : PRDATA;
                        err_q   <= PSLVERR;
                        tmo_q   <= 1'b0;
                        state_q <= StResp;
                    end else if (TimeoutEn && (wait_q == WaitLast)) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                        state_q <= StResp;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake and APB phase strobes decode from state only.
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
        PSEL        = (state_q == StSetup) || (state_q == StAccess);
        PENABLE     = (state_q == StAccess);
    end

    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tmo_q;

endmodule
